// File: rtl/registerfile_pkg.sv
// Shared constants and type helpers for the parametrised register file
// and the multicycle control unit that drives it.
package registerfile_pkg;

    // Defaults match the original 4 x 8-bit factorial datapath register file.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREGS = 4;
    localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_NREGS);

    // Address and data types for the default configuration.
    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
    typedef logic [DEFAULT_WIDTH-1:0]  data_t;

    // Number of read ports; both behave identically and independently.
    localparam int NUM_READ_PORTS = 2;

endpackage

// File: rtl/registerfile_param_reg_scoreboard.sv
// Per-register pending scoreboard. A bit is set when a producer is issued
// (Reserva) and cleared when that register is written back (EscReg).
// Ocupado tells the control unit that some result is still outstanding.
module reg_scoreboard
    import registerfile_pkg::*;
#(
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Limpa,
    input  logic              Reserva,
    input  logic [ADDR_W-1:0] RegRes,
    input  logic              EscReg,
    input  logic [ADDR_W-1:0] RegEsc,
    output logic [NREGS-1:0]  pending,
    output logic              Ocupado
);

    logic             reserveEn;
    logic             clearEn;
    logic [NREGS-1:0] pendingNext;

    // A hardwired zero register can never be reserved or cleared by a write.
    always_comb begin
        reserveEn = Reserva;
        clearEn   = EscReg;
        if (ZERO_REG && (RegRes == '0)) begin
            reserveEn = 1'b0;
        end
        if (ZERO_REG && (RegEsc == '0)) begin
            clearEn = 1'b0;
        end
    end

    // Next pending vector: a new reservation beats a same-cycle write-back,
    // because the write belongs to the previous producer.
    always_comb begin
        pendingNext = pending;
        for (int i = 0; i < NREGS; i++) begin
            if (reserveEn && (RegRes == ADDR_W'(i))) begin
                pendingNext[i] = 1'b1;
            end else if (clearEn && (RegEsc == ADDR_W'(i))) begin
                pendingNext[i] = 1'b0;
            end
        end
    end

    // Pending flags: async reset, synchronous bank clear has top priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (Limpa) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    // Busy whenever any result is outstanding.
    always_comb begin
        Ocupado = |pending;
    end

endmodule

// File: rtl/registerfile_param.sv
// Parametrised two-read / one-write register file with optional write
// bypass, optional hardwired zero register, synchronous bank clear and a
// pending scoreboard used by the control unit to stall on operands.
module registerfile_param
    import registerfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    output logic [WIDTH-1:0]  Data1,
    output logic [WIDTH-1:0]  Data2,
    output logic              Pend1,
    output logic              Pend2,
    input  logic              EscReg,
    input  logic [ADDR_W-1:0] RegEsc,
    input  logic [WIDTH-1:0]  DadoEscr,
    input  logic              Reserva,
    input  logic [ADDR_W-1:0] RegRes,
    input  logic              Limpa,
    output logic              Ocupado
);

    logic [WIDTH-1:0] regFile [NREGS];
    logic [NREGS-1:0] pending;
    logic             writeEn;
    logic             bypass1;
    logic             bypass2;
    logic             zero1;
    logic             zero2;

    // Effective write: suppressed by the bank clear and, when configured,
    // for the hardwired zero register.
    always_comb begin
        writeEn = EscReg && !Limpa;
        if (ZERO_REG && (RegEsc == '0)) begin
            writeEn = 1'b0;
        end
    end

    // Register storage: async reset, synchronous clear, single write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (Limpa) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (writeEn) begin
            regFile[RegEsc] <= DadoEscr;
        end
    end

    // Bypass only forwards a write that will actually land, so a write
    // masked by Limpa or aimed at the zero register is never forwarded.
    always_comb begin
        bypass1 = BYPASS && writeEn && (RegEsc == Read1);
        bypass2 = BYPASS && writeEn && (RegEsc == Read2);
        zero1   = ZERO_REG && (Read1 == '0);
        zero2   = ZERO_REG && (Read2 == '0);
    end

    // Read port 1: zero register, then bypassed write data, then storage.
    // A forwarded write reports not-pending even if a new reservation lands
    // on the same register this cycle; that bit appears next cycle.
    always_comb begin
        Data1 = regFile[Read1];
        Pend1 = pending[Read1];
        if (zero1) begin
            Data1 = '0;
            Pend1 = 1'b0;
        end else if (bypass1) begin
            Data1 = DadoEscr;
            Pend1 = 1'b0;
        end
    end

    // Read port 2: same selection as port 1, fully independent.
    always_comb begin
        Data2 = regFile[Read2];
        Pend2 = pending[Read2];
        if (zero2) begin
            Data2 = '0;
            Pend2 = 1'b0;
        end else if (bypass2) begin
            Data2 = DadoEscr;
            Pend2 = 1'b0;
        end
    end

    reg_scoreboard #(
        .NREGS   (NREGS),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) scoreboard (
        .clock  (clock),
        .reset  (reset),
        .Limpa  (Limpa),
        .Reserva(Reserva),
        .RegRes (RegRes),
        .EscReg (EscReg),
        .RegEsc (RegEsc),
        .pending(pending),
        .Ocupado(Ocupado)
    );

endmodule

// File: doc/registerfile_param.md
# registerfile_param

Parametrised successor of the 4×8-bit two-read/one-write register file used by the factorial datapath. Adds configurable width and depth, optional same-cycle write-to-read bypass, optional hardwired zero register, synchronous bank clear, and a per-register pending scoreboard. The scoreboard lets the multicycle control unit stall on operands whose producing operation (e.g. the iterative multiplier) has not yet written back.

## Interface
Parameters:
- WIDTH, 8, data width of each register
- NREGS, 4, number of registers (≥2, power of two)
- ADDR_W, $clog2(NREGS), derived; never overridden
- BYPASS, 1, 1 = read ports see DadoEscr in the cycle it is written
- ZERO_REG, 0, 1 = register 0 reads as 0, is never written, never pending

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all registers and pending bits
- Read1, Read2  in  ADDR_W  read addresses
- Data1, Data2  out  WIDTH  read data
- Pend1, Pend2  out  1  addressed register has an outstanding reservation
- EscReg  in  1  write enable
- RegEsc  in  ADDR_W  write address
- DadoEscr  in  WIDTH  write data
- Reserva  in  1  mark RegRes pending (producer issued)
- RegRes  in  ADDR_W  register to reserve
- Limpa  in  1  synchronous clear of all registers and pending bits
- Ocupado  out  1  OR of all pending bits

## Operation
- Reads are combinational from Read1/Read2; both ports independent, may alias each other and the write address.
- Write: at posedge with EscReg=1, reg[RegEsc] ← DadoEscr and pending[RegEsc] ← 0.
- Reserve: at posedge with Reserva=1, pending[RegRes] ← 1.
- Reserve and write to the same register in one cycle: data is written, pending ends at 1 (new producer wins).
- Limpa=1: all registers ← 0, all pending ← 0; overrides EscReg and Reserva that cycle.
- Bypass (BYPASS=1): if EscReg=1 and RegEsc==ReadN, DataN = DadoEscr and PendN = 0 in that cycle (unless Reserva targets the same register; PendN still reflects current state, i.e. 0). BYPASS=0: DataN shows stored value, PendN shows stored bit.
- ZERO_REG=1: address 0 → Data=0, Pend=0; writes/reserves to 0 ignored; bypass does not apply to 0.
- Pending bits are plain flags; reserving an already-pending register is harmless (stays 1).

## Timing
- Reset (async assert, released synchronously by the system): all registers 0, all pending 0; hence Data1=Data2=0, Pend1=Pend2=0, Ocupado=0 for any address.
- Write latency: 1 cycle to storage; 0 cycles to read ports when BYPASS=1.
- Reserve latency: PendN and Ocupado rise the cycle after Reserva.
- Reset mid-operation: in-flight writes and reservations lost; no partial state.
- Address out of range impossible (NREGS power of two).

## Structure
- Package registerfile_pkg: default WIDTH/NREGS constants and the addr/data typedef helpers shared with the control unit.
- One sub-module natural: reg_scoreboard (NREGS pending bits, reserve/clear/Limpa logic, Ocupado); storage and read muxes stay in registerfile_param.

## Test plan
- Reset then read all addresses -> Data=0, Pend=0, Ocupado=0; write 8'hA5 to reg 2, next cycle Read1=2 -> Data1=8'hA5.
- BYPASS=1, EscReg=1 RegEsc=3 DadoEscr=8'h3C, Read2=3 same cycle -> Data2=8'h3C, Pend2=0; BYPASS=0 -> old value until next cycle.
- Reserva reg 1 -> next cycle Pend1=1 on Read1=1, Ocupado=1; write 8'h18 to reg 1 -> next cycle Pend1=0, Data1=8'h18, Ocupado=0.
- Same-cycle Reserva and EscReg on reg 2 with 8'h07 -> reg 2 = 8'h07, pending=1.
- ZERO_REG=1: write 8'hFF to reg 0, Reserva reg 0 -> Data=0, Pend=0, Ocupado=0.
- Regs loaded, reg 1 pending, assert Limpa with concurrent write -> all 0, Ocupado=0; async reset mid-cycle -> outputs 0 immediately.
